// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence host slice.
package geofence_pkg;

    localparam int COORD_W     = 10;
    localparam int PTS_PER_SET = 7;

    // Engine-slot sequencer states.
    typedef enum logic [1:0] {
        DRIVE = 2'd0,
        WAIT  = 2'd1,
        LOST  = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    // Result FIFO occupancy after this edge's push and pop both take effect.
    function automatic logic [1:0] fifo_occ_next(
        input logic [1:0] cnt,
        input logic       push,
        input logic       pop
    );
        return cnt + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/geofence_if.sv
// Point-in and result-out streams between the host fabric and geofence_host.
interface geofence_if #(
    parameter int TAG_W = 8
);
    import geofence_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [COORD_W-1:0] s_x;
    logic [COORD_W-1:0] s_y;
    logic               r_valid;
    logic               r_ready;
    logic               r_inside;
    logic               r_timeout;
    logic [TAG_W-1:0]   r_tag;

    modport master (
        output s_valid, s_x, s_y, r_ready,
        input  s_ready, r_valid, r_inside, r_timeout, r_tag
    );

    modport slave (
        input  s_valid, s_x, s_y, r_ready,
        output s_ready, r_valid, r_inside, r_timeout, r_tag
    );

endinterface

// File: rtl/geofence_set_buf.sv
// Two-bank, 7-point set store. A bank commits on its 7th point and stays
// committed (so it cannot be overwritten) until the launcher frees it.
module geofence_set_buf
    import geofence_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  point_t     in_pt,
    output logic       in_ready,
    output logic       head_valid,
    output logic       head_bank,
    input  logic       free_en,
    input  logic       rd_bank,
    input  logic [2:0] rd_idx,
    output point_t     rd_pt
);

    point_t     mem_r [2][PTS_PER_SET];
    logic [1:0] commit_r;
    logic       wr_bank_r;
    logic       head_bank_r;
    logic [2:0] wr_idx_r;
    logic       accept_s;
    logic       commit_now_s;

    assign in_ready     = ~commit_r[wr_bank_r];
    assign accept_s     = in_valid & in_ready;
    assign commit_now_s = accept_s & (wr_idx_r == 3'd6);
    // A set completing on this very edge is launchable at the same edge.
    assign head_valid   = commit_r[head_bank_r] | (commit_now_s & (wr_bank_r == head_bank_r));
    assign head_bank    = head_bank_r;

    // Point storage and fill pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < PTS_PER_SET; p++) begin
                    mem_r[b][p] <= '0;
                end
            end
            wr_bank_r <= 1'b0;
            wr_idx_r  <= 3'd0;
        end else if (accept_s) begin
            mem_r[wr_bank_r][wr_idx_r] <= in_pt;
            if (commit_now_s) begin
                wr_bank_r <= ~wr_bank_r;
                wr_idx_r  <= 3'd0;
            end else begin
                wr_idx_r  <= wr_idx_r + 3'd1;
            end
        end
    end

    // Per-bank commit flags; commit and free never target the same bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_r <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (commit_now_s && (wr_bank_r == 1'(b))) begin
                    commit_r[b] <= 1'b1;
                end else if (free_en && (head_bank_r == 1'(b))) begin
                    commit_r[b] <= 1'b0;
                end
            end
        end
    end

    // Oldest committed bank advances when freed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_bank_r <= 1'b0;
        end else if (free_en) begin
            head_bank_r <= ~head_bank_r;
        end
    end

    // Read port used by the launcher.
    always_comb begin
        rd_pt = '0;
        if (rd_idx <= 3'd6) begin
            rd_pt = mem_r[rd_bank][rd_idx];
        end else begin
            rd_pt = '0;
        end
    end

endmodule

// File: rtl/geofence_host.sv
// Drives the free-running geofence engine in its 7-cycle window, watches for
// its result (with a watchdog) and returns tagged results through a 2-deep FIFO.
module geofence_host
    import geofence_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    geofence_if.slave          bus,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    input  logic               valid,
    input  logic               is_inside,
    output logic               busy
);

    localparam int         WD_W    = $clog2(TIMEOUT + 1);
    localparam int         RES_W   = TAG_W + 2;
    localparam logic [1:0] S_DRIVE = DRIVE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_LOST  = LOST;

    logic [1:0]         state_r;
    logic [2:0]         pt_idx_r;
    logic               real_r;
    logic               bank_r;
    logic [WD_W-1:0]    wd_cnt_r;
    logic [TAG_W-1:0]   tag_r;
    logic [TAG_W-1:0]   set_tag_r;
    logic               busy_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [RES_W-1:0]   fifo_mem_r [2];
    logic               fifo_wr_r;
    logic               fifo_rd_r;
    logic [1:0]         fifo_cnt_r;

    logic               start_s;
    logic               push_s;
    logic [RES_W-1:0]   push_data_s;
    logic               pop_s;
    logic               r_valid_s;
    logic [RES_W-1:0]   head_s;
    logic               launch_real_s;
    logic               free_en_s;
    logic               head_valid_s;
    logic               head_bank_s;
    logic               rd_bank_s;
    point_t             rd_pt_s;
    point_t             in_pt_s;
    logic               in_ready_s;

    assign in_pt_s = {bus.s_x, bus.s_y};

    geofence_set_buf u_set_buf (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (bus.s_valid),
        .in_pt      (in_pt_s),
        .in_ready   (in_ready_s),
        .head_valid (head_valid_s),
        .head_bank  (head_bank_s),
        .free_en    (free_en_s),
        .rd_bank    (rd_bank_s),
        .rd_idx     (pt_idx_r),
        .rd_pt      (rd_pt_s)
    );

    // Slot-start detection and result push selection; valid wins over expiry.
    always_comb begin
        start_s     = 1'b0;
        push_s      = 1'b0;
        push_data_s = '0;
        case (state_r)
            S_DRIVE: begin
                start_s = (pt_idx_r == 3'd0);
            end
            S_WAIT: begin
                start_s = valid;
                if (valid) begin
                    push_s      = real_r;
                    push_data_s = {is_inside, 1'b0, set_tag_r};
                end else if (wd_cnt_r == WD_W'(TIMEOUT)) begin
                    push_s      = real_r;
                    push_data_s = {1'b0, 1'b1, set_tag_r};
                end else begin
                    push_s      = 1'b0;
                end
            end
            S_LOST: begin
                start_s = valid;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    assign r_valid_s     = (fifo_cnt_r != 2'd0);
    assign pop_s         = r_valid_s & bus.r_ready;
    assign launch_real_s = start_s & head_valid_s & (fifo_occ_next(fifo_cnt_r, push_s, pop_s) < 2'd2);
    assign free_en_s     = (state_r == S_DRIVE) & (pt_idx_r == 3'd6) & real_r;
    assign rd_bank_s     = start_s ? head_bank_s : bank_r;

    // Slot sequencer, coordinate registers and watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= S_DRIVE;
            pt_idx_r <= 3'd0;
            real_r   <= 1'b0;
            bank_r   <= 1'b0;
            wd_cnt_r <= '0;
            x_r      <= '0;
            y_r      <= '0;
        end else if (start_s) begin
            state_r  <= S_DRIVE;
            pt_idx_r <= 3'd1;
            real_r   <= launch_real_s;
            bank_r   <= head_bank_s;
            wd_cnt_r <= '0;
            x_r      <= launch_real_s ? rd_pt_s.x : '0;
            y_r      <= launch_real_s ? rd_pt_s.y : '0;
        end else begin
            case (state_r)
                S_DRIVE: begin
                    x_r <= real_r ? rd_pt_s.x : '0;
                    y_r <= real_r ? rd_pt_s.y : '0;
                    if (pt_idx_r == 3'd6) begin
                        state_r  <= S_WAIT;
                        pt_idx_r <= 3'd0;
                        wd_cnt_r <= '0;
                    end else begin
                        pt_idx_r <= pt_idx_r + 3'd1;
                    end
                end
                S_WAIT: begin
                    if (wd_cnt_r == WD_W'(TIMEOUT)) begin
                        state_r <= S_LOST;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_W'(1);
                    end
                end
                S_LOST: begin
                    state_r <= S_LOST;
                end
                default: begin
                    state_r  <= S_DRIVE;
                    pt_idx_r <= 3'd0;
                end
            endcase
        end
    end

    // Tag allocation at each real launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_r     <= '0;
            set_tag_r <= '0;
        end else if (launch_real_s) begin
            set_tag_r <= tag_r;
            tag_r     <= tag_r + TAG_W'(1);
        end
    end

    // In-flight flag: set at real launch, cleared once its result is pushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else if (launch_real_s) begin
            busy_r <= 1'b1;
        end else if (push_s) begin
            busy_r <= 1'b0;
        end
    end

    // Two-entry fall-through result FIFO; push and pop may coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            fifo_wr_r     <= 1'b0;
            fifo_rd_r     <= 1'b0;
            fifo_cnt_r    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[fifo_wr_r] <= push_data_s;
                fifo_wr_r             <= ~fifo_wr_r;
            end
            if (pop_s) begin
                fifo_rd_r <= ~fifo_rd_r;
            end
            fifo_cnt_r <= fifo_occ_next(fifo_cnt_r, push_s, pop_s);
        end
    end

    assign head_s        = fifo_mem_r[fifo_rd_r];
    assign bus.s_ready   = in_ready_s;
    assign bus.r_valid   = r_valid_s;
    assign bus.r_inside  = r_valid_s & head_s[RES_W-1];
    assign bus.r_timeout = r_valid_s & head_s[RES_W-2];
    assign bus.r_tag     = r_valid_s ? head_s[TAG_W-1:0] : '0;
    assign X             = x_r;
    assign Y             = y_r;
    assign busy          = busy_r;

endmodule
